cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
Sending end of a 4-phase req/ack clock-domain crossing. It accepts a word from a local valid/ready source and launches it on tx_data with tx_req. It then waits for tx_ack, which arrives asynchronously from a foreign domain and is synchronized internally. The receiving end is a multi-flop synchronizer on tx_req in the foreign domain. A timeout guards against a dead receiver.

Parameters:
DATA_W, 8, width of the transferred word
SYNC_STAGES, 2, flops in the tx_ack synchronizer chain (legal values 2..4)
TIMEOUT, 255, cycles allowed in each wait state before abort; 0 disables the timeout

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  local source has a word
in_ready  out  1  block can accept a word this cycle
in_data  in  DATA_W  word to send
tx_req  out  1  request to foreign domain; registered, glitch-free
tx_data  out  DATA_W  registered payload; stable whenever tx_req=1
tx_ack  in  1  acknowledge from foreign domain; asynchronous to clk
busy  out  1  high in any state other than IDLE
timeout_err  out  1  one-cycle pulse when a wait state times out

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, tx_req=0, tx_data=0, timeout_err=0, counter=0, synchronizer flops=0.
  - Applies mid-transfer: tx_req drops at that edge; no error pulse.
- ack_s: tx_ack after SYNC_STAGES flops. The FSM uses only ack_s and never samples raw tx_ack.
- in_ready = (state==IDLE) && !ack_s. It is combinational from registers only, with no path from in_valid.
- States and transitions:
  - IDLE: on in_valid && in_ready, tx_data<=in_data and go to SETUP.
  - SETUP: exactly 1 cycle, tx_req still 0, so data is stable one cycle before the req edge. Next state REQ, tx_req<=1.
  - REQ: hold tx_req=1 until ack_s=1, then tx_req<=0 and go to REL.
  - REL: tx_req=0; wait for ack_s=0, then go to IDLE.
- tx_data changes only on acceptance in IDLE. It holds through SETUP/REQ/REL and after return to IDLE.
- Latency, with acceptance at edge k:
  - tx_req rises at k+1.
  - After tx_ack rises, tx_req falls SYNC_STAGES+1 edges later, counting the first edge that samples tx_ack=1.
  - After tx_ack falls, busy drops SYNC_STAGES+1 edges later.
  - Minimum transfer period with an instant-ack receiver is 2*SYNC_STAGES+4 cycles.
- Timeout counter: cleared on entry to REQ and to REL, incremented every cycle in those states. It saturates at TIMEOUT and is never wider than needed for TIMEOUT.
  - REQ timeout (count==TIMEOUT && !ack_s): pulse timeout_err, tx_req<=0, go to REL.
  - REL timeout (count==TIMEOUT && ack_s): pulse timeout_err, go to IDLE. in_ready stays low while ack_s=1, so no new transfer starts against a stuck-high ack.
  - If the ack condition and the timeout coincide in the same cycle, the ack wins and there is no error.
- in_valid while busy: ignored, no capture. The source holds the word until in_ready.
- tx_ack high at reset release: in_ready stays 0 until ack_s=0.

Decomposition:
- Shared package cdc_pkg holds:
  - state enum tx_state_t {IDLE, SETUP, REQ, REL}, 2 bits
  - constant SYNC_STAGES_MIN=2
- One sub-module, sync_ff #(STAGES): a plain flop chain with synchronous reset to 0, reused by the future receiving end.

Test Plan:
- Single transfer, SYNC_STAGES=2, in_data=8'hA5 at edge 10; bench ack = tx_req delayed 3 cycles -> tx_req rises at 11, tx_data=8'hA5 from 10 onward, tx_req falls 3 edges after ack rise, busy drops 3 edges after ack fall.
- Back-to-back: source holds in_valid with 8'h01 then 8'h02 -> two complete 4-phase cycles, tx_data 01 then 02, in_ready never high while busy, no word lost or duplicated.
- Dead receiver, TIMEOUT=16, tx_ack tied 0 -> tx_req high 17 cycles, timeout_err pulses exactly once, returns to IDLE with tx_req=0.
- Stuck ack: tx_ack rises, never falls, TIMEOUT=16 -> timeout_err pulse in REL, then in_ready stays 0 until tx_ack=0 plus 2 cycles.
- Reset mid-REQ: rst=1 for 1 cycle while tx_req=1 -> tx_req=0, tx_data=0, busy=0 at the next edge, no timeout_err; next transfer behaves normally.
- Async ack jitter: tx_ack toggled at non-multiples of the clock period (7, 13, 19 ns offsets) -> tx_req sequence unchanged apart from ±1-cycle synchronizer latency; tx_data never changes while tx_req=1.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types for the req/ack clock-domain-crossing handshake blocks.
// Holds the sending-side FSM state encoding and the synchronizer depth floor.
// No logic of its own; imported by the sending end and the synchronizer.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } tx_state_t;

  // Two flops is the shallowest chain that gives metastability time to resolve.
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/sync_ff.sv
// Plain flop-chain synchronizer for a single asynchronous bit.
// Latency: STAGES clk edges from the first edge that samples a new d value.
// Backpressure: none; free-running shift every cycle.
// Ports: clk (sampling clock), rst (sync active-high, clears chain to 0),
//        d (asynchronous input), q (synchronized output).
module sync_ff
  import cdc_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Sending end of a 4-phase req/ack crossing: local valid/ready word -> tx_data/tx_req.
// Latency: tx_req rises 1 edge after acceptance; falls SYNC_STAGES+1 edges after tx_ack rises.
// Backpressure: in_ready is low for the whole transfer and while the synchronized ack is high.
// Ports: clk/rst (sync active-high); in_valid/in_ready/in_data (local source);
//        tx_req/tx_data (to foreign domain), tx_ack (async from foreign domain);
//        busy (not IDLE), timeout_err (one-cycle pulse on a wait-state timeout).
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,   // 2..4
  parameter int TIMEOUT     = 255  // 0 disables the timeout
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ack,
  output logic              busy,
  output logic              timeout_err
);

  // Counter only as wide as TIMEOUT needs; one bit when the timeout is disabled.
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             ack_s;
  logic             timeout_hit;

  // The FSM only ever looks at ack_s; raw tx_ack goes nowhere else.
  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (tx_ack),
    .q   (ack_s)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_MAX);

  // Blocking on ack_s keeps a new transfer from starting against a receiver
  // that still holds (or is stuck with) ack high.
  assign in_ready = (state == IDLE) && !ack_s;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            tx_data <= in_data;
            state   <= SETUP;
          end
        end
        // One cycle with data launched but req still low, so the payload has
        // settled before the receiver can see the req edge.
        SETUP: begin
          tx_req <= 1'b1;
          cnt    <= '0;
          state  <= REQ;
        end
        // Ack is checked before the timeout so a coincident ack is not an error.
        REQ: begin
          if (ack_s) begin
            tx_req <= 1'b0;
            cnt    <= '0;
            state  <= REL;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            tx_req      <= 1'b0;
            cnt         <= '0;
            state       <= REL;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REL: begin
          if (!ack_s) begin
            state <= IDLE;
          end else if (timeout_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
module tb_cdc_handshake_tx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              tx_req;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ack;
  logic              busy;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  int                to_pulses = 0;
  int                req_rises = 0;
  bit                mon_en    = 1'b0;
  logic              prev_req  = 1'b0;
  logic [DATA_W-1:0] held;
  logic [DATA_W-1:0] mon_exp;

  // Receiver models: 0 = tx_req delayed 3 cycles, 1 = forced level, 2 = timed jitter.
  logic [2:0] ack_dly = 3'b000;
  logic [1:0] ack_sel = 2'd1;
  logic       ack_force_val = 1'b0;
  logic       ack_jit = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) ack_dly <= {ack_dly[1:0], tx_req};

  assign tx_ack = (ack_sel == 2'd0) ? ack_dly[2] :
                  (ack_sel == 2'd1) ? ack_force_val : ack_jit;

  cdc_handshake_tx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_ack      (tx_ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Scoreboard / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (timeout_err) to_pulses++;
      checks++;
      if (busy && in_ready) begin
        failures++;
        $display("FAIL ready_while_busy in_ready=%0b busy=%0b want in_ready=0", in_ready, busy);
      end
      if (tx_req && !prev_req) begin
        req_rises++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_req tx_data=%0h want no request", tx_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if (tx_data !== mon_exp) begin
            failures++;
            $display("FAIL sb_data got=%0h want=%0h", tx_data, mon_exp);
          end
        end
        held = tx_data;
      end else if (tx_req) begin
        checks++;
        if (tx_data !== held) begin
          failures++;
          $display("FAIL data_stable_during_req got=%0h want=%0h", tx_data, held);
        end
      end
      prev_req = tx_req;
    end
  end

  // Presents a word, waits (bounded) for in_ready, returns at the negedge after the handshake edge.
  task automatic send(input logic [DATA_W-1:0] w, input bit hold_after);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_accept in_ready=%0b want=1 within 200 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(w);
      @(negedge clk);
      if (!hold_after) in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (!(busy === 1'b0 && in_ready === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(busy === 1'b0 && in_ready === 1'b1)) begin
      failures++;
      $display("FAIL wait_idle busy=%0b in_ready=%0b want busy=0 in_ready=1", busy, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    ack_sel = 2'd1; ack_force_val = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_req !== 1'b0) begin failures++; $display("FAIL reset_tx_req got=%0b want=0", tx_req); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h want=0", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0b want=0", timeout_err); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_single;
    int n;
    int p0;
    ack_sel = 2'd0;
    repeat (4) @(negedge clk);
    p0 = to_pulses;
    send(8'hA5, 1'b0);
    // Just after the acceptance edge: SETUP, data already launched, req still low.
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_setup got=%0h want=a5", tx_data); end
    checks++; if (tx_req !== 1'b0) begin failures++; $display("FAIL single_req_setup got=%0b want=0", tx_req); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0b want=1", busy); end
    @(negedge clk);
    checks++; if (tx_req !== 1'b1) begin failures++; $display("FAIL single_req_rise got=%0b want=1", tx_req); end
    n = 0;
    while (tx_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (tx_req === 1'b1 && n < 30);
    checks++; if (n != SYNC_STAGES + 1) begin failures++; $display("FAIL single_req_fall_latency got=%0d want=%0d", n, SYNC_STAGES + 1); end
    n = 0;
    while (tx_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (busy === 1'b1 && n < 30);
    checks++; if (n != SYNC_STAGES + 1) begin failures++; $display("FAIL single_busy_drop_latency got=%0d want=%0d", n, SYNC_STAGES + 1); end
    wait_idle();
    checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_hold_idle got=%0h want=a5", tx_data); end
    checks++; if (to_pulses != p0) begin failures++; $display("FAIL single_no_timeout got=%0d want=%0d", to_pulses, p0); end
  endtask

  task automatic test_back_to_back;
    int r0;
    ack_sel = 2'd0;
    r0 = req_rises;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    wait_idle();
    checks++; if (req_rises - r0 != 2) begin failures++; $display("FAIL b2b_transfers got=%0d want=2", req_rises - r0); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_sb_drain got=%0d pending want=0", exp_q.size()); end
    checks++; if (tx_data !== 8'h02) begin failures++; $display("FAIL b2b_last_data got=%0h want=02", tx_data); end
  endtask

  task automatic test_dead_receiver;
    int n;
    int p0;
    ack_sel = 2'd1; ack_force_val = 1'b0;
    p0 = to_pulses;
    send(8'h5A, 1'b0);
    @(negedge clk);
    n = 0;
    while (tx_req === 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != TIMEOUT + 1) begin failures++; $display("FAIL dead_req_high_cycles got=%0d want=%0d", n, TIMEOUT + 1); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL dead_timeout_pulse got=%0b want=1", timeout_err); end
    wait_idle();
    checks++; if (to_pulses - p0 != 1) begin failures++; $display("FAIL dead_pulse_count got=%0d want=1", to_pulses - p0); end
    checks++; if (tx_req !== 1'b0) begin failures++; $display("FAIL dead_req_low got=%0b want=0", tx_req); end
  endtask

  task automatic test_stuck_ack;
    int n;
    int p0;
    ack_sel = 2'd1; ack_force_val = 1'b0;
    p0 = to_pulses;
    send(8'hC3, 1'b0);
    @(negedge clk);
    checks++; if (tx_req !== 1'b1) begin failures++; $display("FAIL stuck_req_rise got=%0b want=1", tx_req); end
    ack_force_val = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (tx_req === 1'b1 && n < 30);
    checks++; if (n != SYNC_STAGES + 1) begin failures++; $display("FAIL stuck_req_fall_latency got=%0d want=%0d", n, SYNC_STAGES + 1); end
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (n != TIMEOUT + 1) begin failures++; $display("FAIL stuck_rel_timeout_cycles got=%0d want=%0d", n, TIMEOUT + 1); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stuck_idle_after_timeout busy=%0b want=0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stuck_ready_blocked got=%0b want=0", in_ready); end
    checks++; if (to_pulses - p0 != 1) begin failures++; $display("FAIL stuck_pulse_count got=%0d want=1", to_pulses - p0); end
    ack_force_val = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (in_ready !== 1'b1 && n < 30);
    checks++; if (n != SYNC_STAGES) begin failures++; $display("FAIL stuck_ready_release_latency got=%0d want=%0d", n, SYNC_STAGES); end
  endtask

  task automatic test_reset_mid_req;
    int p0;
    ack_sel = 2'd1; ack_force_val = 1'b0;
    p0 = to_pulses;
    send(8'h96, 1'b0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx_req !== 1'b0) begin failures++; $display("FAIL rstmid_tx_req got=%0b want=0", tx_req); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rstmid_tx_data got=%0h want=0", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b want=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL rstmid_timeout_err got=%0b want=0", timeout_err); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    ack_sel = 2'd0;
    send(8'h3C, 1'b0);
    @(negedge clk);
    checks++; if (tx_req !== 1'b1) begin failures++; $display("FAIL rstmid_next_req_rise got=%0b want=1", tx_req); end
    wait_idle();
    checks++; if (tx_data !== 8'h3C) begin failures++; $display("FAIL rstmid_next_data got=%0h want=3c", tx_data); end
    checks++; if (to_pulses != p0) begin failures++; $display("FAIL rstmid_no_timeout got=%0d want=%0d", to_pulses, p0); end
  endtask

  task automatic test_ack_jitter;
    int offs[3] = '{7, 13, 19};
    int n;
    ack_sel = 2'd2; ack_jit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(DATA_W'(8'h10 + i), 1'b0);
      @(negedge clk);
      checks++; if (tx_req !== 1'b1) begin failures++; $display("FAIL jitter_req_rise[%0d] got=%0b want=1", i, tx_req); end
      #(offs[i]);
      ack_jit = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (tx_req === 1'b1 && n < 20);
      checks++; if (n != SYNC_STAGES + 1) begin failures++; $display("FAIL jitter_req_fall[%0d] got=%0d want=%0d", i, n, SYNC_STAGES + 1); end
      @(negedge clk);
      #(offs[(i + 1) % 3]);
      ack_jit = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (busy === 1'b1 && n < 20);
      checks++; if (n != SYNC_STAGES + 1) begin failures++; $display("FAIL jitter_busy_drop[%0d] got=%0d want=%0d", i, n, SYNC_STAGES + 1); end
      @(negedge clk);
      wait_idle();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_dead_receiver();
    test_stuck_ack();
    test_reset_mid_req();
    test_ack_jitter();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_final_drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time expired, test sequence did not complete");
    $fatal(1, "watchdog");
  end

endmodule
